// File: rtl/afe_ro_serial_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : afe_ro_serial_rx                                                 |
// | Brief   : Oversampled 3-wire AFE serial receiver with stretched valid.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module afe_ro_serial_rx #(
  parameter int AFE_DATA_WIDTH = 32,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      cfg_en_i,
  input  logic                      cfg_cpol_i,
  input  logic                      cfg_msb_first_i,
  input  logic [4:0]                cfg_frame_len_i,
  input  logic [3:0]                cfg_stretch_i,
  input  logic                      afe_cs_ni,
  input  logic                      afe_sclk_i,
  input  logic                      afe_sdata_i,
  output logic [AFE_DATA_WIDTH-1:0] afe_data_o,
  output logic                      afe_data_valid_o,
  output logic                      frame_err_o,
  output logic                      overrun_o,
  output logic                      busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  // Synchronizers; r_fill marks when the chain holds post-reset samples.
  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_sdata_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES:0]   r_fill;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sclk_sync  <= '0;
      r_sdata_sync <= '0;
      r_cs_sync    <= '1;
      r_fill       <= '0;
    end else begin
      r_sclk_sync  <= {r_sclk_sync[SYNC_STAGES-2:0], afe_sclk_i};
      r_sdata_sync <= {r_sdata_sync[SYNC_STAGES-2:0], afe_sdata_i};
      r_cs_sync    <= {r_cs_sync[SYNC_STAGES-2:0], afe_cs_ni};
      r_fill       <= {r_fill[SYNC_STAGES-1:0], 1'b1};
    end
  end

  logic r_sclk_q;
  logic r_sclk_qq;
  logic r_sdata_q;
  logic r_cs_q;
  logic r_cs_qq;
  logic r_armed;

  // A frame already running at reset release is ignored until CS is seen high.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sclk_q  <= 1'b0;
      r_sclk_qq <= 1'b0;
      r_sdata_q <= 1'b0;
      r_cs_q    <= 1'b1;
      r_cs_qq   <= 1'b1;
      r_armed   <= 1'b0;
    end else begin
      r_sclk_q  <= r_sclk_sync[SYNC_STAGES-1];
      r_sclk_qq <= r_sclk_q;
      r_sdata_q <= r_sdata_sync[SYNC_STAGES-1];
      r_cs_q    <= r_cs_sync[SYNC_STAGES-1];
      r_cs_qq   <= r_cs_q;
      r_armed   <= r_armed | (r_fill[SYNC_STAGES] & r_cs_q);
    end
  end

  logic w_sclk_edge;
  logic w_cs_fall;

  assign w_sclk_edge = cfg_cpol_i ? (r_sclk_qq & ~r_sclk_q) : (~r_sclk_qq & r_sclk_q);
  assign w_cs_fall   = r_armed & r_cs_qq & ~r_cs_q;

  state_t      r_state;
  logic [31:0] r_sr;
  logic [4:0]  r_cnt;
  logic        r_done;
  logic        r_ferr;
  logic        r_busy;
  logic [31:0] w_sr_next;
  logic        w_last;

  always_comb begin
    w_sr_next = r_sr;
    if (cfg_msb_first_i) begin
      w_sr_next = {r_sr[30:0], r_sdata_q};
    end else begin
      w_sr_next[r_cnt] = r_sdata_q;
    end
  end

  assign w_last = (r_cnt == cfg_frame_len_i);

  // The completed word stays in r_sr through WAIT, where it is read by the output stage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
      r_sr    <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_ferr  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_ferr <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (cfg_en_i && w_cs_fall) begin
            r_state <= ST_SHIFT;
            r_sr    <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (!cfg_en_i) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (w_sclk_edge) begin
            r_sr  <= w_sr_next;
            r_cnt <= r_cnt + 5'd1;
            if (w_last) begin
              r_done  <= 1'b1;
              r_state <= ST_WAIT;
            end
          end else if (r_cs_q) begin
            r_ferr  <= 1'b1;
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (!cfg_en_i || r_cs_q) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  logic [AFE_DATA_WIDTH-1:0] r_data;
  logic                      r_valid;
  logic [3:0]                r_stretch;
  logic                      r_frame_err;
  logic                      r_overrun;

  // Valid is held for cfg_stretch_i+1 cycles; words completing inside that window are dropped.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_stretch   <= '0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= r_ferr;
      r_overrun   <= r_done & r_valid;
      if (r_done && !r_valid) begin
        r_data    <= AFE_DATA_WIDTH'(r_sr);
        r_valid   <= 1'b1;
        r_stretch <= cfg_stretch_i;
      end else if (r_valid) begin
        if (r_stretch == 4'd0) begin
          r_valid <= 1'b0;
        end else begin
          r_stretch <= r_stretch - 4'd1;
        end
      end
    end
  end

  assign afe_data_o       = r_data;
  assign afe_data_valid_o = r_valid;
  assign frame_err_o      = r_frame_err;
  assign overrun_o        = r_overrun;
  assign busy_o           = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_afe_ro_serial_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_afe_ro_serial_rx                                              |
// | Brief   : Directed table-driven bench for afe_ro_serial_rx.                |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_afe_ro_serial_rx;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        cfg_en_i = 1'b1;
  logic        cfg_cpol_i = 1'b0;
  logic        cfg_msb_first_i = 1'b1;
  logic [4:0]  cfg_frame_len_i = 5'd31;
  logic [3:0]  cfg_stretch_i = 4'd3;
  logic        afe_cs_ni = 1'b1;
  logic        afe_sclk_i = 1'b0;
  logic        afe_sdata_i = 1'b0;
  logic [31:0] afe_data_o;
  logic        afe_data_valid_o;
  logic        frame_err_o;
  logic        overrun_o;
  logic        busy_o;

  afe_ro_serial_rx #(.AFE_DATA_WIDTH(32), .SYNC_STAGES(2)) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .cfg_en_i        (cfg_en_i),
    .cfg_cpol_i      (cfg_cpol_i),
    .cfg_msb_first_i (cfg_msb_first_i),
    .cfg_frame_len_i (cfg_frame_len_i),
    .cfg_stretch_i   (cfg_stretch_i),
    .afe_cs_ni       (afe_cs_ni),
    .afe_sclk_i      (afe_sclk_i),
    .afe_sdata_i     (afe_sdata_i),
    .afe_data_o      (afe_data_o),
    .afe_data_valid_o(afe_data_valid_o),
    .frame_err_o     (frame_err_o),
    .overrun_o       (overrun_o),
    .busy_o          (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Cumulative event counters; each test snapshots them and checks the delta.
  int   m_vcyc = 0, m_vrise = 0, m_err = 0, m_ovr = 0;
  int   m_rise_cyc = 0, m_err_cyc = 0;
  logic m_vprev = 1'b0;
  always @(negedge clk_i) begin
    if (afe_data_valid_o) begin
      m_vcyc = m_vcyc + 1;
      if (!m_vprev) begin
        m_vrise    = m_vrise + 1;
        m_rise_cyc = cyc;
      end
    end
    if (frame_err_o) begin
      m_err     = m_err + 1;
      m_err_cyc = cyc;
    end
    if (overrun_o) m_ovr = m_ovr + 1;
    m_vprev = afe_data_valid_o;
  end

  int total = 0;
  int bad = 0;
  int edge_cyc [64];
  int cs_cyc = 0;
  int b_vcyc, b_vrise, b_err, b_ovr;

  typedef struct {
    logic        en;
    logic        msb;
    logic        cpol;
    logic [4:0]  flen;
    logic [3:0]  str;
    logic [31:0] word;
    int          nedge;
    logic        exp_valid;
    logic [31:0] exp_data;
    int          exp_err;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic snap();
    b_vcyc  = m_vcyc;
    b_vrise = m_vrise;
    b_err   = m_err;
    b_ovr   = m_ovr;
  endtask

  function automatic logic [63:0] mk_stream(input logic [31:0] w, input int len, input logic msb);
    logic [63:0] s;
    s = '1;
    for (int i = 0; i < len; i++) s[i] = msb ? w[len-1-i] : w[i];
    return s;
  endfunction

  task automatic frame_begin(input logic cpol);
    afe_sclk_i  = cpol;
    afe_sdata_i = 1'b0;
    wclk(6);
    afe_cs_ni = 1'b0;
    wclk(6);
  endtask

  task automatic shift_bits(input logic [63:0] st, input int from, input int to, input logic cpol);
    for (int i = from; i < to; i++) begin
      afe_sdata_i = st[i];
      wclk(4);
      afe_sclk_i  = ~cpol;
      edge_cyc[i] = cyc + 1;
      wclk(4);
      afe_sclk_i  = cpol;
    end
  endtask

  task automatic frame_end();
    wclk(4);
    afe_cs_ni = 1'b1;
    cs_cyc    = cyc + 1;
    wclk(30);
  endtask

  initial begin
    logic [63:0] st;
    vec_t        v;

    //          en    msb   cpol  flen   str   word           n   val   exp_data      err
    tbl[0] = '{1'b1, 1'b1, 1'b0, 5'd31, 4'd3,  32'hDEADBEEF, 32, 1'b1, 32'hDEADBEEF, 0};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 5'd11, 4'd1,  32'h00000A5C, 12, 1'b1, 32'h00000A5C, 0};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 5'd15, 4'd2,  32'h00001234,  7, 1'b0, 32'h00000A5C, 1};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 5'd15, 4'd2,  32'h0000BEEF, 16, 1'b1, 32'h0000BEEF, 0};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 5'd31, 4'd0,  32'h89ABCDEF, 40, 1'b1, 32'h89ABCDEF, 0};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 5'd0,  4'd0,  32'h00000001,  1, 1'b1, 32'h00000001, 0};
    tbl[6] = '{1'b1, 1'b0, 1'b1, 5'd31, 4'd7,  32'hF00DCAFE, 32, 1'b1, 32'hF00DCAFE, 0};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 5'd4,  4'd15, 32'h00000015,  5, 1'b1, 32'h00000015, 0};
    tbl[8] = '{1'b0, 1'b1, 1'b0, 5'd7,  4'd1,  32'h00000077,  8, 1'b0, 32'h00000015, 0};

    // Reset state
    wclk(3);
    chk("reset data", 64'(afe_data_o), 64'h0);
    chk("reset valid", 64'(afe_data_valid_o), 64'h0);
    chk("reset frame_err", 64'(frame_err_o), 64'h0);
    chk("reset overrun", 64'(overrun_o), 64'h0);
    chk("reset busy", 64'(busy_o), 64'h0);
    rst_ni = 1'b1;
    wclk(6);

    for (int k = 0; k < 9; k++) begin
      v = tbl[k];
      cfg_en_i        = v.en;
      cfg_msb_first_i = v.msb;
      cfg_cpol_i      = v.cpol;
      cfg_frame_len_i = v.flen;
      cfg_stretch_i   = v.str;
      st = mk_stream(v.word, int'(v.flen) + 1, v.msb);
      snap();
      frame_begin(v.cpol);
      shift_bits(st, 0, v.nedge, v.cpol);
      frame_end();
      chk($sformatf("v%0d valid_rises", k), 64'(m_vrise - b_vrise), v.exp_valid ? 64'd1 : 64'd0);
      chk($sformatf("v%0d valid_cycles", k), 64'(m_vcyc - b_vcyc),
          v.exp_valid ? 64'(int'(v.str) + 1) : 64'd0);
      chk($sformatf("v%0d data", k), 64'(afe_data_o), 64'(v.exp_data));
      chk($sformatf("v%0d frame_err", k), 64'(m_err - b_err), 64'(v.exp_err));
      chk($sformatf("v%0d overrun", k), 64'(m_ovr - b_ovr), 64'd0);
      chk($sformatf("v%0d busy_after", k), 64'(busy_o), 64'd0);
      if (v.exp_valid)
        chk($sformatf("v%0d valid_latency", k), 64'(m_rise_cyc - edge_cyc[v.flen]), 64'd4);
      if (v.exp_err != 0)
        chk($sformatf("v%0d err_latency", k), 64'(m_err_cyc - cs_cyc), 64'd4);
    end

    // Overrun: S=16, two L=1 frames completing 10 cycles apart
    cfg_en_i = 1'b1; cfg_msb_first_i = 1'b1; cfg_cpol_i = 1'b0;
    cfg_frame_len_i = 5'd0; cfg_stretch_i = 4'd15;
    snap();
    frame_begin(1'b0);
    afe_sdata_i = 1'b1;
    wclk(4);
    afe_sclk_i = 1'b1;
    wclk(4);
    afe_sclk_i = 1'b0; afe_cs_ni = 1'b1; afe_sdata_i = 1'b0;
    wclk(3);
    afe_cs_ni = 1'b0;
    wclk(3);
    afe_sclk_i = 1'b1;
    wclk(4);
    afe_sclk_i = 1'b0;
    frame_end();
    chk("ovr overrun_pulses", 64'(m_ovr - b_ovr), 64'd1);
    chk("ovr valid_rises", 64'(m_vrise - b_vrise), 64'd1);
    chk("ovr valid_cycles", 64'(m_vcyc - b_vcyc), 64'd16);
    chk("ovr data", 64'(afe_data_o), 64'h1);
    chk("ovr frame_err", 64'(m_err - b_err), 64'd0);

    // Reset at bit 20, remainder of the frame after release must be ignored
    cfg_frame_len_i = 5'd31; cfg_stretch_i = 4'd3;
    st = mk_stream(32'h13579BDF, 32, 1'b1);
    frame_begin(1'b0);
    shift_bits(st, 0, 20, 1'b0);
    chk("rst busy_midframe", 64'(busy_o), 64'd1);
    rst_ni = 1'b0;
    #1;
    chk("rst data_now", 64'(afe_data_o), 64'h0);
    chk("rst valid_now", 64'(afe_data_valid_o), 64'h0);
    chk("rst busy_now", 64'(busy_o), 64'h0);
    wclk(3);
    rst_ni = 1'b1;
    snap();
    wclk(2);
    shift_bits(st, 20, 32, 1'b0);
    frame_end();
    chk("rst tail_valid_rises", 64'(m_vrise - b_vrise), 64'd0);
    chk("rst tail_frame_err", 64'(m_err - b_err), 64'd0);
    chk("rst tail_data", 64'(afe_data_o), 64'h0);

    // Fresh frame after reset recovery
    st = mk_stream(32'hCAFEF00D, 32, 1'b1);
    snap();
    frame_begin(1'b0);
    shift_bits(st, 0, 32, 1'b0);
    frame_end();
    chk("fresh data", 64'(afe_data_o), 64'hCAFEF00D);
    chk("fresh valid_rises", 64'(m_vrise - b_vrise), 64'd1);
    chk("fresh valid_cycles", 64'(m_vcyc - b_vcyc), 64'd4);
    chk("fresh valid_latency", 64'(m_rise_cyc - edge_cyc[31]), 64'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/afe_ro_serial_rx.md
# afe_ro_serial_rx

Front-end capture stage that sits directly upstream of the AFE readout subsystem. It receives a 3-wire serial AFE stream (frame select, serial clock, serial data), oversamples it in the system clock domain, and assembles right-aligned words of up to 32 bits. Each completed word is driven onto one `afe_data_i` / `afe_data_valid_i` lane of the readout subsystem, with the valid pulse stretched so the readout's asynchronous valid capture cannot miss it. Framing errors and overruns are reported as single-cycle pulses.

## Interface
Parameters:
- `AFE_DATA_WIDTH`, 32: output word width; must be ≥ 32.
- `SYNC_STAGES`, 2: synchronizer depth on `afe_sclk_i`, `afe_cs_ni` and `afe_sdata_i`; allowed range 2..3.

Ports (one clock `clk_i`; reset `rst_ni` is asynchronous and active-low):
- `clk_i` in 1: system clock.
- `rst_ni` in 1: asynchronous active-low reset.
- `cfg_en_i` in 1: capture enable.
- `cfg_cpol_i` in 1: 0 = sample on the rising `afe_sclk_i` edge, 1 = sample on the falling edge.
- `cfg_msb_first_i` in 1: bit order.
- `cfg_frame_len_i` in 5: frame length minus 1 (L = value + 1, range 1..32).
- `cfg_stretch_i` in 4: valid high time minus 1 (S = value + 1 cycles).
- `afe_cs_ni` in 1: asynchronous frame select, active low.
- `afe_sclk_i` in 1: asynchronous serial clock.
- `afe_sdata_i` in 1: asynchronous serial data.
- `afe_data_o` out AFE_DATA_WIDTH: captured word, right-aligned, zero-extended.
- `afe_data_valid_o` out 1: stretched valid.
- `frame_err_o` out 1: single-cycle pulse; frame aborted.
- `overrun_o` out 1: single-cycle pulse; word dropped.
- `busy_o` out 1: high in every state except IDLE.

## Operation
- Every asynchronous input passes through `SYNC_STAGES` flops. The "active edge" is detected on the synchronized `afe_sclk_i` (rising edge if `cfg_cpol_i` = 0, falling edge if 1) by comparing it with its registered copy.
- States:
  - IDLE → SHIFT when `cfg_en_i` = 1 and synced `afe_cs_ni` falls. Entering SHIFT clears the shift register and the bit counter.
  - SHIFT: each active edge shifts in synced `afe_sdata_i`.
    - MSB-first: `sr <= {sr[30:0], d}`.
    - LSB-first: the bit is written to position `cnt`.
    - The counter increments on each shifted bit.
  - SHIFT, on the edge that shifts bit number L: the word is complete and goes to output handling. Next state is WAIT_CS.
  - SHIFT, synced `afe_cs_ni` rises with fewer than L bits: pulse `frame_err_o`, discard the partial word, go to IDLE.
  - WAIT_CS: active edges are ignored. When synced `afe_cs_ni` rises, go to IDLE.
- Output handling:
  - Normal case: on word completion with the stretch counter at 0, latch `afe_data_o`, raise `afe_data_valid_o`, and load the stretch counter with S.
  - Valid drops when the stretch counter reaches 0.
  - `afe_data_o` holds its value until the next accepted word.
  - Overrun: a word that completes while `afe_data_valid_o` is still high is dropped. `overrun_o` pulses and `afe_data_o` is unchanged.
- `cfg_en_i` deasserted:
  - Mid-frame: abort to IDLE with no error pulse.
  - A valid pulse already in progress still runs to completion.
- Configuration inputs must be static while `busy_o` = 1. Configuration changes during a frame give undefined data but must not hang the state machine.
- Bit ordering: bit 0 received LSB-first lands in `afe_data_o[0]`. For MSB-first with L = 12, the first bit received lands in `afe_data_o[11]`.

## Timing
- Reset values: `afe_data_o` = 0, `afe_data_valid_o` = 0, `frame_err_o` = 0, `overrun_o` = 0, `busy_o` = 0, state = IDLE, all synchronizers = 0, except the `afe_cs_ni` synchronizer, which resets to 1.
- Latency (`SYNC_STAGES` = 2): `afe_data_valid_o` rises on the 4th `clk_i` rising edge after the first edge that samples the final active `afe_sclk_i` level. The same latency applies to `frame_err_o` relative to the sample of `afe_cs_ni` high.
- Latency for other depths is `SYNC_STAGES` + 2.
- Input constraints: the `afe_sclk_i` high and low phases must each last ≥ `SYNC_STAGES` + 1 `clk_i` cycles. Data must be stable for ≥ 1 cycle around the active edge.
- `afe_data_valid_o` is high for exactly S cycles.
- The earliest next accepted word is the one completing at least S cycles after the previous valid rise.
- Asserting reset mid-frame or mid-stretch immediately forces every output to its reset value. A frame in progress when reset releases is ignored until `afe_cs_ni` is seen high, then low again.

## Test plan
- MSB-first, L = 32, S = 4, frame 0xDEADBEEF with `cfg_cpol_i` = 0, sclk period 8 cycles → `afe_data_o` = 0xDEADBEEF, valid high for 4 cycles, rising 4 cycles after the last sampled edge.
- LSB-first, L = 12 (`cfg_frame_len_i` = 11), bits 0xA5C sent LSB first, `cfg_cpol_i` = 1 → `afe_data_o` = 0x00000A5C, no error pulses.
- `afe_cs_ni` deasserted after 7 of 16 bits → one `frame_err_o` pulse, valid stays 0, `afe_data_o` keeps its previous value. The next full frame is captured correctly.
- S = 16, two back-to-back L = 1 frames 10 cycles apart → the first word is captured, `overrun_o` pulses once, and the second word is dropped.
- 40 edges sent with L = 32 → one word from the first 32 bits, 8 extra edges ignored, no error.
- Reset asserted at bit 20 of a frame → outputs 0 at once. After release, with `afe_cs_ni` still low, the remainder of that frame produces no valid. A fresh frame captures correctly.
